fifo_flagged: RTL
=================

// Module: fifo_flagged
// PURPOSE
//   Parametrised synchronous show-ahead FIFO; successor to the plain circular buffer used between
//   pipeline stages. Adds full/empty, an occupancy count, programmable almost-full/almost-empty
//   thresholds, a synchronous flush and sticky overflow/underflow error flags. Supports any depth
//   >= 2, including non-power-of-2 depths. Single clock domain.
// PARAMETERS
//   DATA_WIDTH  25   width of DI/DO
//   DEPTH       256  number of entries, >= 2, any integer
//   AFULL_TH    DEPTH-2  almost_full asserted when count >= AFULL_TH (1..DEPTH)
//   AEMPTY_TH   1    almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
// PORTS
//   clk           in   1           rising-edge clock
//   rst           in   1           asynchronous reset, active-high
//   clr           in   1           synchronous flush, active-high
//   DI            in   DATA_WIDTH  write data
//   wren          in   1           write request
//   rden          in   1           read request (pops head)
//   DO            out  DATA_WIDTH  head entry (show-ahead); 0 when empty
//   full          out  1           count == DEPTH
//   empty         out  1           count == 0
//   almost_full   out  1           count >= AFULL_TH
//   almost_empty  out  1           count <= AEMPTY_TH
//   count         out  CW          occupancy, CW = clogb2(DEPTH+1)
//   overflow      out  1           sticky: write attempted while full without a read
//   underflow     out  1           sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (async, rst=1): rd_ptr=wr_ptr=0, count=0, overflow=underflow=0 -> empty=1, full=0,
//     almost_empty=1, almost_full=0 (unless AFULL_TH==0, disallowed), DO=0. Storage is not reset.
//   - Pointers: width clogb2(DEPTH-1); increment, wrap from DEPTH-1 to 0 (explicit compare,
//     not natural overflow).
//   - Accepted write: wren & (!full | rden); mem[wr_ptr]<=DI, wr_ptr advances.
//   - Accepted read:  rden & !empty; rd_ptr advances. Data was visible on DO before the edge.
//   - count: +1 on write-only, -1 on read-only, unchanged on both or neither.
//   - Full & wren & rden: both accepted; count stays DEPTH; no overflow.
//   - Empty & wren & rden: write accepted, read ignored; count -> 1; underflow set.
//   - Full & wren & !rden: write dropped, memory/pointers unchanged, overflow set.
//   - Empty & rden: ignored, underflow set.
//   - DO = empty ? 0 : mem[rd_ptr]; combinational from registered state only (no path from DI,
//     wren or rden). A write into an empty FIFO appears on DO the cycle after the edge.
//   - All flags are decoded from the registered count; no combinational path from inputs.
//   - clr (sync): highest priority below rst. Pointers, count, overflow, underflow -> 0 at the
//     edge; any wren/rden in that cycle is ignored and does not set error flags.
//   - overflow/underflow stay set until rst or clr.
//   - Async rst mid-operation discards contents immediately; outputs reach reset values without
//     a clock edge.
// TESTING (DEPTH=4, DATA_WIDTH=8, AFULL_TH=3, AEMPTY_TH=1 unless stated)
//   - Reset, then write 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at count 3, full at 4;
//     DO=0x11 one cycle after the first write.
//   - Full, write 0x55 with no read -> dropped, overflow=1, count=4; read 4 times -> DO sequence
//     11,22,33,44, then empty=1, DO=0.
//   - Full, wren&rden with DI=0x66 -> count stays 4, DO advances to 0x22; after wrap, 0x66
//     is read last.
//   - Empty, wren&rden with DI=0x77 -> count=1, DO=0x77, underflow=1.
//   - DEPTH=5: 12 writes interleaved with reads -> pointers wrap 4->0 and data order is kept.
//   - Count=3 with sticky flags set, pulse clr with wren=1 -> count=0, flags cleared, write lost;
//     assert rst between edges -> outputs reset immediately.

Source files
------------

// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock show-ahead FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, a synchronous flush and
// sticky overflow/underflow flags. Any DEPTH >= 2 is supported, including
// depths that are not a power of two.
//
// Handshake: a write is accepted when wren & (!full | rden), so a full FIFO
// can take a write in the same cycle as a read. A read is accepted when
// rden & !empty. DO always shows the head entry before the edge that pops
// it. No ready/valid output depends combinationally on wren, rden or DI.
module fifo_flagged #(
    parameter int DATA_WIDTH = 25,
    parameter int DEPTH      = 256,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int AEMPTY_TH  = 1,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int PW        = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  wren,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Pointers wrap by explicit compare so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Acceptance decode; flags come from registered count only.
    always_comb begin
        wr_accept = wren & (!full | rden);
        rd_accept = rden & !empty;
    end

    // Status flags and show-ahead data, decoded from registered state.
    always_comb begin
        full         = (count == CW'(DEPTH));
        empty        = (count == '0);
        almost_full  = (count >= CW'(AFULL_TH));
        almost_empty = (count <= CW'(AEMPTY_TH));
        DO           = empty ? '0 : mem[rd_ptr];
    end

    // Storage is not reset; only accepted writes land in memory.
    always_ff @(posedge clk) begin
        if (!clr && wr_accept) begin
            mem[wr_ptr] <= DI;
        end
    end

    // Pointer, occupancy and sticky error flag state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_accept) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (wr_accept && !rd_accept) begin
                count <= count + CW'(1);
            end else if (rd_accept && !wr_accept) begin
                count <= count - CW'(1);
            end
            if (wren && full && !rden) begin
                overflow <= 1'b1;
            end
            if (rden && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
